sbox_share_sched: RTL and testbench

//  Time-multiplexes a bank of NUM_SBOX combinational AES S-boxes between two requesters:
//  the round datapath (SubBytes, 16-byte state) and key expansion (SubWord, 4-byte word).

---
 rtl/aes_sbox_pkg.sv | 38 +++
 rtl/sbox_bank.sv | 15 +
 rtl/sbox_share_sched.sv | 133 +++++++++++++
 tb/tb_sbox_share_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sbox_pkg.sv
// aes_sbox_pkg: shared widths, FSM/requester enums, slice-count helper and AES S-box lookup.
package aes_sbox_pkg;

    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KS, DRAIN} fsm_t;
    typedef enum logic {REQ_ST, REQ_KS} req_t;

    function automatic int num_slices(input int n, input req_t r);
        return (r == REQ_ST) ? 16 / n : ((n >= 4) ? 1 : 4 / n);
    endfunction

    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TBL[a];
    endfunction

endpackage

// File: rtl/sbox_bank.sv
// sbox_bank: NUM_SBOX parallel combinational AES S-boxes on a flat byte bus.
module sbox_bank
    import aes_sbox_pkg::*;
#(
    parameter int NUM_SBOX = 4
) (
    input  logic [NUM_SBOX*BYTE_W-1:0] din,
    output logic [NUM_SBOX*BYTE_W-1:0] dout
);

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
        assign dout[g*BYTE_W +: BYTE_W] = sbox(din[g*BYTE_W +: BYTE_W]);
    end

endmodule

// File: rtl/sbox_share_sched.sv
// sbox_share_sched: round-robin time-multiplexing of a NUM_SBOX S-box bank between SubBytes and SubWord jobs.
// SBOX_PIPE_EN: adds a register after the bank and a DRAIN state (+1 cycle to done).
module sbox_share_sched
    import aes_sbox_pkg::*;
#(
    parameter int NUM_SBOX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st_req,
    input  logic [STATE_W-1:0] st_in,
    output logic               st_ack,
    output logic               st_done,
    output logic [STATE_W-1:0] st_out,
    input  logic               ks_req,
    input  logic [WORD_W-1:0]  ks_in,
    output logic               ks_ack,
    output logic               ks_done,
    output logic [WORD_W-1:0]  ks_out,
    output logic               busy
);

    localparam int LW    = NUM_SBOX * BYTE_W;
    localparam int ST_SL = num_slices(NUM_SBOX, REQ_ST);
    localparam int KS_SL = num_slices(NUM_SBOX, REQ_KS);
    localparam int KB    = ((NUM_SBOX > 4) ? NUM_SBOX : 4) * BYTE_W;
`ifdef SBOX_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
        $error("sbox_share_sched: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    fsm_t               state, state_nxt;
    req_t               last_grant;
    logic [3:0]         cnt, cnt_nxt;
    logic [STATE_W-1:0] op, res, res_nxt;
    logic [LW-1:0]      feed, bank_out, wr_data;
    logic               run, last, wr_v, wr_last, wr_ks, fin_st, fin_ks;

    assign run    = (state == RUN_ST) || (state == RUN_KS);
    assign last   = cnt == ((state == RUN_KS) ? 4'(KS_SL - 1) : 4'(ST_SL - 1));
    assign st_ack = !rst && (state == IDLE) && st_req && (!ks_req || last_grant == REQ_KS);
    assign ks_ack = !rst && (state == IDLE) && ks_req && (!st_req || last_grant == REQ_ST);
    assign busy   = state != IDLE;
    // operand shifts left one slice per cycle, so the current slice is always the top lanes
    assign feed   = op[STATE_W-1 -: LW];

    always_comb begin
        state_nxt = (state == IDLE) ? (st_ack ? RUN_ST : ks_ack ? RUN_KS : IDLE)
                  : (run && !last)  ? state
                  : (run && PIPE)   ? DRAIN
                  :                   IDLE;
        cnt_nxt   = (run && !last) ? cnt + 4'd1 : 4'd0;
    end

    sbox_bank #(.NUM_SBOX(NUM_SBOX)) u_bank (
        .din  (feed),
        .dout (bank_out)
    );

`ifdef SBOX_PIPE_EN
    logic          pipe_v, pipe_last, pipe_ks;
    logic [LW-1:0] pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v    <= 1'b0;
            pipe_last <= 1'b0;
            pipe_ks   <= 1'b0;
            pipe_q    <= '0;
        end else begin
            pipe_v    <= run;
            pipe_last <= run && last;
            pipe_ks   <= state == RUN_KS;
            pipe_q    <= bank_out;
        end
    end

    assign wr_v    = pipe_v;
    assign wr_last = pipe_last;
    assign wr_ks   = pipe_ks;
    assign wr_data = pipe_q;
`else
    assign wr_v    = run;
    assign wr_last = last;
    assign wr_ks   = state == RUN_KS;
    assign wr_data = bank_out;
`endif

    // results shift in from the bottom; a key word ends up in the low KB bits
    assign res_nxt = (res << LW) | STATE_W'(wr_data);
    assign fin_st  = wr_v && wr_last && !wr_ks;
    assign fin_ks  = wr_v && wr_last && wr_ks;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= REQ_ST;
            op         <= '0;
            res        <= '0;
            st_out     <= '0;
            ks_out     <= '0;
            st_done    <= 1'b0;
            ks_done    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (st_ack) begin
                last_grant <= REQ_ST;
                op         <= st_in;
            end else if (ks_ack) begin
                last_grant <= REQ_KS;
                op         <= {ks_in, {(STATE_W-WORD_W){1'b0}}};
            end else if (run) begin
                op <= op << LW;
            end
            if (wr_v)
                res <= res_nxt;
            if (fin_st)
                st_out <= res_nxt;
            if (fin_ks)
                ks_out <= res_nxt[KB-1 -: WORD_W];
            st_done <= fin_st;
            ks_done <= fin_ks;
        end
    end

endmodule

// File: tb/tb_sbox_share_sched.sv
// tb_sbox_share_sched: directed checks of sbox_share_sched at NUM_SBOX=4 (main), 1 and 16 (key jobs).
// Honours SBOX_PIPE_EN for the expected latencies.
module tb_sbox_share_sched;

`ifdef SBOX_PIPE_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         st_req[3], ks_req[3];
    logic [127:0] st_in[3], st_out[3];
    logic [31:0]  ks_in[3], ks_out[3];
    logic         st_ack[3], st_done[3], ks_ack[3], ks_done[3], busy[3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sbox_share_sched #(.NUM_SBOX(4)) u_s4 (
        .clk(clk), .rst(rst),
        .st_req(st_req[0]), .st_in(st_in[0]), .st_ack(st_ack[0]), .st_done(st_done[0]), .st_out(st_out[0]),
        .ks_req(ks_req[0]), .ks_in(ks_in[0]), .ks_ack(ks_ack[0]), .ks_done(ks_done[0]), .ks_out(ks_out[0]),
        .busy(busy[0])
    );

    sbox_share_sched #(.NUM_SBOX(1)) u_s1 (
        .clk(clk), .rst(rst),
        .st_req(st_req[1]), .st_in(st_in[1]), .st_ack(st_ack[1]), .st_done(st_done[1]), .st_out(st_out[1]),
        .ks_req(ks_req[1]), .ks_in(ks_in[1]), .ks_ack(ks_ack[1]), .ks_done(ks_done[1]), .ks_out(ks_out[1]),
        .busy(busy[1])
    );

    sbox_share_sched #(.NUM_SBOX(16)) u_s16 (
        .clk(clk), .rst(rst),
        .st_req(st_req[2]), .st_in(st_in[2]), .st_ack(st_ack[2]), .st_done(st_done[2]), .st_out(st_out[2]),
        .ks_req(ks_req[2]), .ks_in(ks_in[2]), .ks_ack(ks_ack[2]), .ks_done(ks_done[2]), .ks_out(ks_out[2]),
        .busy(busy[2])
    );

    typedef struct {
        logic [127:0] st_in;
        logic [127:0] st_exp;
        logic [31:0]  ks_in;
        logic [31:0]  ks_exp;
    } vec_t;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int ks_lat(input int i);
        return ((i == 1) ? 5 : 2) + P;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic grant_st(input logic [127:0] d);
        int k = 0;
        st_in[0]  = d;
        st_req[0] = 1'b1;
        #1;
        while (!st_ack[0] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("st_ack_seen", 128'(st_ack[0]), 128'd1);
        @(posedge clk);
        #1;
        st_req[0] = 1'b0;
    endtask

    task automatic wait_st(input logic [127:0] e, input string nm);
        int k = 1;
        @(negedge clk);
        while (!st_done[0] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_lat"}, 128'(k), 128'(5 + P));
        chk({nm, "_out"}, st_out[0], e);
    endtask

    task automatic grant_ks(input int i, input logic [31:0] d);
        int k = 0;
        ks_in[i]  = d;
        ks_req[i] = 1'b1;
        #1;
        while (!ks_ack[i] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("ks_ack_seen[%0d]", i), 128'(ks_ack[i]), 128'd1);
        @(posedge clk);
        #1;
        ks_req[i] = 1'b0;
    endtask

    task automatic wait_ks(input int i, input logic [31:0] e, input string nm);
        int k = 1;
        @(negedge clk);
        while (!ks_done[i] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("%s_lat[%0d]", nm, i), 128'(k), 128'(ks_lat(i)));
        chk($sformatf("%s_out[%0d]", nm, i), 128'(ks_out[i]), 128'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        bit   seen;
        bit   prev_st;
        int   acks, cyc;

        vecs[0] = '{FIPS_IN, FIPS_OUT, 32'hcf4f3c09, 32'h8a84eb01};
        vecs[1] = '{{4{32'h005301ff}}, {4{32'h63ed7c16}}, 32'h005301ff, 32'h63ed7c16};
        vecs[2] = '{{4{32'h5301ff00}}, {4{32'hed7c1663}}, 32'h5301ff00, 32'hed7c1663};
        vecs[3] = '{{4{32'h01ff0053}}, {4{32'h7c1663ed}}, 32'h01ff0053, 32'h7c1663ed};
        vecs[4] = '{{4{32'hff005301}}, {4{32'h1663ed7c}}, 32'hff005301, 32'h1663ed7c};
        vecs[5] = '{128'h0, {16{8'h63}}, 32'hffffffff, 32'h16161616};

        for (int i = 0; i < 3; i++) begin
            st_req[i] = 1'b0;
            ks_req[i] = 1'b0;
            st_in[i]  = '0;
            ks_in[i]  = '0;
        end

        // reset state, then abort a state job with a mid-run reset
        do_reset();
        #1;
        chk("rst_st_ack", 128'(st_ack[0]), 128'd0);
        chk("rst_ks_ack", 128'(ks_ack[0]), 128'd0);
        chk("rst_st_done", 128'(st_done[0]), 128'd0);
        chk("rst_ks_done", 128'(ks_done[0]), 128'd0);
        chk("rst_st_out", st_out[0], 128'd0);
        chk("rst_ks_out", 128'(ks_out[0]), 128'd0);
        chk("rst_busy", 128'(busy[0]), 128'd0);
        @(negedge clk);
        grant_st(FIPS_IN);
        chk("run_busy", 128'(busy[0]), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 128'(busy[0]), 128'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= st_done[0];
        end
        chk("abort_no_done", 128'(seen), 128'd0);
        chk("abort_st_out", st_out[0], 128'd0);

        // vector table: state job on the 4-lane DUT, key jobs on all three widths
        for (int v = 0; v < 6; v++) begin
            grant_st(vecs[v].st_in);
            wait_st(vecs[v].st_exp, $sformatf("st_vec%0d", v));
            for (int i = 0; i < 3; i++) begin
                grant_ks(i, vecs[v].ks_in);
                wait_ks(i, vecs[v].ks_exp, $sformatf("ks_vec%0d", v));
            end
            chk($sformatf("st_hold_vec%0d", v), st_out[0], vecs[v].st_exp);
        end

        // simultaneous requests after reset: key first, state granted in the key done cycle
        do_reset();
        st_in[0]  = FIPS_IN;
        ks_in[0]  = 32'hcf4f3c09;
        st_req[0] = 1'b1;
        ks_req[0] = 1'b1;
        #1;
        chk("both_ks_ack", 128'(ks_ack[0]), 128'd1);
        chk("both_st_ack", 128'(st_ack[0]), 128'd0);
        @(posedge clk);
        #1;
        ks_req[0] = 1'b0;
        wait_ks(0, 32'h8a84eb01, "both_ks");
        chk("both_st_ack_in_done", 128'(st_ack[0]), 128'd1);
        @(posedge clk);
        #1;
        st_req[0] = 1'b0;
        wait_st(FIPS_OUT, "both_st");

        // continuous requests: alternating grants, each issued in the previous done cycle
        st_req[0] = 1'b1;
        ks_req[0] = 1'b1;
        acks      = 0;
        cyc       = 0;
        prev_st   = 1'b0;
        #1;
        while (acks < 10 && cyc < 400) begin
            if (st_ack[0] || ks_ack[0]) begin
                chk("rr_one_ack", 128'(st_ack[0] && ks_ack[0]), 128'd0);
                if (acks > 0) begin
                    chk($sformatf("rr_alt%0d", acks), 128'(st_ack[0]), 128'(!prev_st));
                    chk($sformatf("rr_b2b%0d", acks), 128'(st_done[0] || ks_done[0]), 128'd1);
                end
                prev_st = st_ack[0];
                acks++;
            end
            chk("rr_one_done", 128'(st_done[0] && ks_done[0]), 128'd0);
            if (st_done[0]) chk("rr_st_out", st_out[0], FIPS_OUT);
            if (ks_done[0]) chk("rr_ks_out", 128'(ks_out[0]), 128'h8a84eb01);
            if (acks < 10) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("rr_acks", 128'(acks), 128'd10);
        @(posedge clk);
        #1;
        st_req[0] = 1'b0;
        ks_req[0] = 1'b0;
        if (prev_st) wait_st(FIPS_OUT, "rr_last_st");
        else         wait_ks(0, 32'h8a84eb01, "rr_last_ks");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
